// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, reset PC and the fetch buffer entry type
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam int JIDX_W = 26;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: two-entry instruction FIFO; push into a full buffer succeeds when popped the same cycle
import pipeline_pkg::*;
module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  fetch_entry_t mem [2];
  logic rd_ptr, wr_ptr, do_push, do_pop;
  logic [1:0] count;
  assign empty = count == 2'd0;
  assign full = count == 2'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, single-outstanding imem requests and redirect handling
import pipeline_pkg::*;
module fetch_stage #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic            redirect_is_jump,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] redirect_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);
  logic [XLEN-1:0] pc, pc4, target;
  logic inflight, push, pop, full, empty, room;
  fetch_entry_t push_data, head;
  assign pc4 = redirect_pc + 32'd4;
  assign target = (redirect_is_jump ? {pc4[31:28], redirect_imm[JIDX_W-1:0], 2'b00}
                                    : pc4 + (redirect_imm << 2)) & ~32'd3;
  assign pop = out_valid & out_ready;
  assign push = inflight & ~redirect_valid;
  // occupancy after this cycle's pop plus the in-flight return must leave a free slot
  assign room = empty | (~full & (pop | ~inflight)) | (pop & ~inflight);
  assign imem_req = ~rst & ~redirect_valid & room;
  assign imem_addr = pc;
  // pc has already advanced past the returning request
  assign push_data = '{instr: imem_rdata, pc: pc - 32'd4};
  assign out_valid = ~empty;
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  assign out_pc_plus4 = empty ? '0 : head.pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) pc <= pc + 32'd4;
    end
  end
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .push_data(push_data),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage against an addr-as-data memory
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, redirect_valid = 1'b0, redirect_is_jump = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata, redirect_pc = '0, redirect_imm = '0;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  int vectors = 0, miscompares = 0;
  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_is_jump(redirect_is_jump),
    .redirect_pc(redirect_pc),
    .redirect_imm(redirect_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    next();
    next();
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_pc4", out_pc_plus4, 0);
    rst = 1'b0;
  endtask
  task automatic redirect(input logic jump, input logic [31:0] pc, input logic [31:0] imm);
    redirect_valid = 1'b1;
    redirect_is_jump = jump;
    redirect_pc = pc;
    redirect_imm = imm;
  endtask
  initial begin
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("seq_req", imem_req, 1);
      check("seq_addr", imem_addr, 32'(4 * k));
      check("seq_valid", out_valid, k >= 2);
      if (k >= 2) begin
        check("seq_pc", out_pc, 32'(4 * (k - 2)));
        check("seq_instr", out_instr, 32'(4 * (k - 2)));
        check("seq_pc4", out_pc_plus4, 32'(4 * (k - 1)));
      end
      next();
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_req", imem_req, k < 2);
      if (k < 2) check("stall_addr", imem_addr, 32'(4 * k));
      else check("stall_pc", out_pc, 0);
      next();
    end
    out_ready = 1'b1;
    #1;
    check("rel_pc0", out_pc, 0);
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 32'h8);
    next();
    #1;
    check("rel_pc4", out_pc, 32'h4);
    next();
    #1;
    check("rel_pc8", out_pc, 32'h8);
    check("rel_instr8", out_instr, 32'h8);
    do_reset();
    out_ready = 1'b1;
    repeat (6) next();
    redirect(1'b0, 32'h10, 32'hFFFF_FFFE);
    #1;
    check("br_head", out_pc, 32'h10);
    check("br_req", imem_req, 0);
    next();
    redirect_valid = 1'b0;
    #1;
    check("br_flush", out_valid, 0);
    check("br_req1", imem_req, 1);
    check("br_addr", imem_addr, 32'h0C);
    next();
    #1;
    check("br_empty", out_valid, 0);
    check("br_addr2", imem_addr, 32'h10);
    next();
    #1;
    check("br_pc", out_pc, 32'h0C);
    check("br_instr", out_instr, 32'h0C);
    next();
    #1;
    check("br_pc2", out_pc, 32'h10);
    redirect(1'b0, 32'h100, 32'h1);
    next();
    redirect(1'b1, 32'hF000_0000, 32'h40);
    #1;
    check("b2b_req", imem_req, 0);
    next();
    redirect_valid = 1'b0;
    #1;
    check("jmp_addr", imem_addr, 32'hF000_0100);
    check("jmp_valid", out_valid, 0);
    next();
    redirect(1'b1, 32'hF000_0000, 32'h03FF_FFFF);
    next();
    redirect_valid = 1'b0;
    #1;
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    next();
    #1;
    check("wrap_addr", imem_addr, 32'h0);
    next();
    #1;
    check("wrap_valid", out_valid, 1);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", out_pc_plus4, 32'h0);
    do_reset();
    next();
    next();
    rst = 1'b1;
    #1;
    check("mid_rst_req", imem_req, 0);
    next();
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_pc", out_pc, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 32'h0);
    next();
    next();
    #1;
    check("restart_valid", out_valid, 1);
    check("restart_pc", out_pc, 32'h0);
    next();
    #1;
    check("restart_pc4", out_pc, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
